mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width; storage is 2**ADDR_W bytes held as 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles inserted before access (legal range 0..15).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  CPU access request, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port addr  input  ADDR_W  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-justified for byte/halfword.
REQ-010 SHALL have port rdata  output  32  load data, valid only while ready=1.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high from acceptance until the ready cycle inclusive.
REQ-013 SHALL have port err  output  1  one-cycle error pulse, coincident with ready.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACCESS, MERGE, RESP.
REQ-015 IDLE: req=1 at an edge SHALL latch we/size/addr/wdata and move to WAIT (LATENCY>0) or ACCESS (LATENCY=0).
REQ-016 WAIT SHALL count LATENCY cycles, then go to ACCESS; request inputs are ignored outside IDLE.
REQ-017 ACCESS: read or word write SHALL complete (write commits at the ACCESS edge) and go to RESP; byte/halfword write SHALL read the target word and go to MERGE.
REQ-018 MERGE SHALL replace only the addressed lanes with wdata low bits, write the word back, and go to RESP.
REQ-019 RESP SHALL assert ready=1 for exactly one cycle, then go to IDLE; a req held high is accepted at the following IDLE edge (no back-to-back acceptance in RESP).
REQ-020 Latency from acceptance edge to ready cycle SHALL be LATENCY+2 cycles for reads and word writes, LATENCY+3 for byte/halfword writes.
REQ-021 Byte order SHALL be little-endian: byte lane k = word bits [8k+7:8k], lane = addr[1:0].
REQ-022 Byte/halfword reads SHALL return the selected lanes zero-extended (sign extension is CPU-side); word reads return the full word.
REQ-023 rdata SHALL be 0 whenever ready=0 or err=1.
REQ-024 Addresses SHALL NOT wrap or alias beyond ADDR_W bits; word index = addr[ADDR_W-1:2].

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, ready=0, busy=0, err=0, rdata=0, clear the wait counter, and discard any in-flight access.
REQ-026 Reset during MERGE SHALL leave the target word at its pre-request value (write-back suppressed).
REQ-027 Reset SHALL NOT clear storage contents; storage powers up to all zeros in simulation.

Configuration
REQ-028 Macro MEM_RESPONDER_MISALIGN_EXC_EN, when defined, SHALL flag halfword with addr[0]=1, word with addr[1:0]!=0, or size=11: storage untouched, err=1 and ready=1 in RESP, same latency as a read.
REQ-029 Without MEM_RESPONDER_MISALIGN_EXC_EN, err SHALL be constant 0, misaligned addresses SHALL be aligned down to the natural boundary, and size=11 SHALL behave as word.

Verification
REQ-030 Word write addr=0x10 wdata=0xDEADBEEF, LATENCY=2 -> ready 4 cycles after acceptance; read addr=0x10 -> rdata=0xDEADBEEF.
REQ-031 After REQ-030, byte write addr=0x12 wdata=0x000000AA -> ready after 5 cycles; word read 0x10 -> 0xDEAABEEF; byte read 0x13 -> 0x000000DE.
REQ-032 Halfword read addr=0x10 after REQ-031 -> rdata=0x0000BEEF; busy high for the full 4 cycles; req pulses during busy ignored (no extra ready).
REQ-033 Reset asserted in MERGE of halfword write 0x10 wdata=0x1234 -> outputs cleared next edge; word read 0x10 -> 0xDEAABEEF.
REQ-034 With macro: word read addr=0x11 -> err=1, ready=1, rdata=0, storage unchanged; without macro: same request -> rdata=contents of 0x10, err=0.
REQ-035 req held high continuously with LATENCY=0 -> ready every 3rd cycle for reads, accesses serviced in order.

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-port word-organised memory that answers CPU byte, halfword and word
//   loads/stores after a configurable number of wait cycles. Sub-word stores
//   are done as read-modify-write (ACCESS reads the word, MERGE writes it back).
//
// Parameters
//   ADDR_W  : byte-address width; storage is 2**(ADDR_W-2) 32-bit words
//   LATENCY : wait cycles inserted before the access (0..15)
//
// Ports
//   clk     : clock, all logic on the rising edge
//   reset   : synchronous active-high reset (storage contents are kept)
//   req     : access request, only looked at while idle
//   we      : 1 = write, 0 = read
//   size    : 00 byte, 01 halfword, 10 word, 11 reserved
//   addr    : byte address (little-endian lanes, lane = addr[1:0])
//   wdata   : store data, right-justified for byte/halfword
//   rdata   : load data, zero-extended, 0 unless ready=1 and err=0
//   ready   : one-cycle completion pulse
//   busy    : high from acceptance up to and including the ready cycle
//   err     : one-cycle error pulse alongside ready
//
// Build option
//   MEM_RESPONDER_MISALIGN_EXC_EN : when defined, misaligned halfword/word
//   accesses and size=11 complete with err=1 and leave storage untouched.
//   When undefined, err is always 0, misaligned addresses are aligned down
//   and size=11 acts as a word access.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    // WAIT is entered with LATENCY-1 and left when the counter reaches zero.
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_MERGE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [3:0]          cnt_r, cnt_nxt_s;
    logic                we_r;
    logic [1:0]          size_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [31:0]         merge_r, merge_nxt_s;
    logic                ready_r, ready_nxt_s;
    logic                err_r, err_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic [31:0]         rdata_r, rdata_nxt_s;
    logic                latch_s;
    logic                mem_we_s;
    logic [31:0]         mem_wdata_s;
    logic [31:0]         mem_r [DEPTH];
    logic [ADDR_W-3:0]   word_idx_s;
    logic [31:0]         rd_word_s;
    logic [4:0]          shift_s;
    logic                subword_s;
    logic                bad_s;

    // Bit offset of the addressed lane group; halfwords are aligned down to lane 0 or 2.
    function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   lane_shift = {lane, 3'b000};
            2'b01:   lane_shift = {lane[1], 1'b0, 3'b000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

    // Zero-extended load of the selected lanes.
    function automatic logic [31:0] load_lanes(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [4:0] sh);
        logic [31:0] t;
        t = word >> sh;
        case (sz)
            2'b00:   load_lanes = {24'd0, t[7:0]};
            2'b01:   load_lanes = {16'd0, t[15:0]};
            default: load_lanes = word;
        endcase
    endfunction

    // Replace only the addressed lanes of old_word with the low bits of new_data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] new_data,
                                                input logic [1:0] sz, input logic [4:0] sh);
        logic [31:0] mask;
        case (sz)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask        = mask << sh;
        merge_lanes = (old_word & ~mask) | ((new_data << sh) & mask);
    endfunction

    assign word_idx_s = addr_r[ADDR_W-1:2];
    assign rd_word_s  = mem_r[word_idx_s];
    assign shift_s    = lane_shift(size_r, addr_r[1:0]);
    assign subword_s  = (size_r == 2'b00) || (size_r == 2'b01);

`ifdef MEM_RESPONDER_MISALIGN_EXC_EN
    assign bad_s = (size_r == 2'b11) ||
                   ((size_r == 2'b01) && addr_r[0]) ||
                   ((size_r == 2'b10) && (addr_r[1:0] != 2'b00));
`else
    assign bad_s = 1'b0;
`endif

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        merge_nxt_s = merge_r;
        ready_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        rdata_nxt_s = 32'd0;
        busy_nxt_s  = busy_r;
        latch_s     = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 32'd0;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    latch_s    = 1'b1;
                    busy_nxt_s = 1'b1;
                    if (LATENCY > 0) begin
                        state_nxt_s = S_WAIT;
                        cnt_nxt_s   = WAIT_INIT;
                    end else begin
                        state_nxt_s = S_ACCESS;
                    end
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_ACCESS;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            S_ACCESS: begin
                if (bad_s) begin
                    state_nxt_s = S_RESP;
                    ready_nxt_s = 1'b1;
                    err_nxt_s   = 1'b1;
                end else if (we_r && subword_s) begin
                    merge_nxt_s = rd_word_s;
                    state_nxt_s = S_MERGE;
                end else if (we_r) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = wdata_r;
                    ready_nxt_s = 1'b1;
                    state_nxt_s = S_RESP;
                end else begin
                    rdata_nxt_s = load_lanes(rd_word_s, size_r, shift_s);
                    ready_nxt_s = 1'b1;
                    state_nxt_s = S_RESP;
                end
            end
            S_MERGE: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = merge_lanes(merge_r, wdata_r, size_r, shift_s);
                ready_nxt_s = 1'b1;
                state_nxt_s = S_RESP;
            end
            S_RESP: begin
                // No acceptance here: a held req is taken at the next IDLE edge.
                busy_nxt_s  = 1'b0;
                state_nxt_s = S_IDLE;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
            merge_r <= 32'd0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            rdata_r <= 32'd0;
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            merge_r <= merge_nxt_s;
            ready_r <= ready_nxt_s;
            err_r   <= err_nxt_s;
            busy_r  <= busy_nxt_s;
            rdata_r <= rdata_nxt_s;
            if (latch_s) begin
                we_r    <= we;
                size_r  <= size;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
        end
    end

    // Storage write port; a reset on the commit edge discards the write.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            mem_r[word_idx_s] <= mem_wdata_s;
        end
    end

    assign rdata = rdata_r;
    assign ready = ready_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'd0;

    logic [31:0] rdata2, rdata0;
    logic        ready2, busy2, err2;
    logic        ready0, busy0, err0;

    mem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Transaction-level model, index 0 = LATENCY 2 instance, 1 = LATENCY 0 instance.
    bit          m_act  [2];
    int          m_done [2];
    int          m_idle [2];
    bit          m_we   [2];
    logic [1:0]  m_size [2];
    int          m_addr [2];
    logic [31:0] m_wdata[2];
    bit          m_bad  [2];
    logic [7:0]  m_mem  [2][256];
    bit          e_ready[2];
    bit          e_busy [2];
    bit          e_err  [2];
    logic [31:0] e_rdata[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge for instance i.
    task automatic model_step(input int i, input int lat_p, input bit rq);
        int nb;
        int base;
        e_ready[i] = 1'b0;
        e_err[i]   = 1'b0;
        e_rdata[i] = 32'd0;
        if (reset) begin
            m_act[i]  = 1'b0;
            e_busy[i] = 1'b0;
            m_idle[i] = cyc + 1;
        end else if (m_act[i]) begin
            if (cyc == m_done[i]) begin
                e_ready[i] = 1'b1;
                if (m_bad[i]) begin
                    e_err[i] = 1'b1;
                end else begin
                    nb   = (m_size[i] == 2'b00) ? 1 : ((m_size[i] == 2'b01) ? 2 : 4);
                    base = m_addr[i] - (m_addr[i] % nb);
                    for (int b = 0; b < nb; b++) begin
                        if (m_we[i]) m_mem[i][base + b] = m_wdata[i][8*b +: 8];
                        else e_rdata[i][8*b +: 8] = m_mem[i][base + b];
                    end
                end
            end else if (cyc == m_done[i] + 1) begin
                m_act[i]  = 1'b0;
                e_busy[i] = 1'b0;
                m_idle[i] = cyc + 1;
            end
        end else if (rq && cyc >= m_idle[i]) begin
            m_act[i]   = 1'b1;
            e_busy[i]  = 1'b1;
            m_we[i]    = we;
            m_size[i]  = size;
            m_addr[i]  = int'(addr);
            m_wdata[i] = wdata;
`ifdef MEM_RESPONDER_MISALIGN_EXC_EN
            m_bad[i] = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                       (size == 2'b10 && addr[1:0] != 2'b00);
`else
            m_bad[i] = 1'b0;
`endif
            m_done[i] = cyc + lat_p + 1 + ((we && size < 2'b10 && !m_bad[i]) ? 1 : 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, 2, req);
            model_step(1, 0, req0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("ready2", ready2, e_ready[0]);
                check("busy2",  busy2,  e_busy[0]);
                check("err2",   err2,   e_err[0]);
                check("rdata2", rdata2, e_rdata[0]);
                check("ready0", ready0, e_ready[1]);
                check("busy0",  busy0,  e_busy[1]);
                check("err0",   err0,   e_err[1]);
                check("rdata0", rdata0, e_rdata[1]);
            end
        end
    end

    // One request on the LATENCY=2 instance; lat is the ready cycle counted from acceptance.
    task automatic do_op(input bit w, input logic [1:0] sz, input logic [7:0] a,
                         input logic [31:0] d, input bit poke,
                         output logic [31:0] got, output bit got_err, output int lat);
        bit seen;
        seen = 1'b0; lat = 0; got = 32'd0; got_err = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; addr = a; wdata = d;
        @(posedge clk);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (poke && (n == 1 || n == 2)) begin
                req = 1'b1; we = 1'b1; size = 2'b10; addr = 8'h10; wdata = 32'h0BAD_F00D;
            end else begin
                req = 1'b0;
            end
            if (ready2) begin
                seen = 1'b1; lat = n; got = rdata2; got_err = err2;
            end
        end
        check("ready_seen", seen, 1'b1);
    endtask

    logic [31:0] got;
    bit          gerr;
    int          lat;

    bit          h_we  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  h_sz  [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [7:0]  h_ad  [6] = '{8'h20, 8'h24, 8'h20, 8'h24, 8'h21, 8'h26};
    logic [31:0] h_wd  [6] = '{32'h0102_0304, 32'h0A0B_0C0D, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] h_exp [6] = '{32'd0, 32'd0, 32'h0102_0304, 32'h0A0B_0C0D, 32'h0000_0003, 32'h0000_0A0B};

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) m_mem[i][j] = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_ready", ready2, 1'b0);
        check("rst_busy",  busy2,  1'b0);

        do_op(1'b1, 2'b10, 8'h10, 32'hDEAD_BEEF, 1'b0, got, gerr, lat);
        check("lat_word_wr", lat, 4);
        do_op(1'b0, 2'b10, 8'h10, 32'd0, 1'b0, got, gerr, lat);
        check("rd_word_10", got, 32'hDEAD_BEEF);
        check("lat_word_rd", lat, 4);
        do_op(1'b1, 2'b00, 8'h12, 32'h0000_00AA, 1'b0, got, gerr, lat);
        check("lat_byte_wr", lat, 5);
        do_op(1'b0, 2'b10, 8'h10, 32'd0, 1'b0, got, gerr, lat);
        check("rd_after_byte", got, 32'hDEAA_BEEF);
        do_op(1'b0, 2'b00, 8'h13, 32'd0, 1'b0, got, gerr, lat);
        check("rd_byte_13", got, 32'h0000_00DE);
        do_op(1'b0, 2'b01, 8'h10, 32'd0, 1'b1, got, gerr, lat);
        check("rd_half_10", got, 32'h0000_BEEF);
        check("lat_half_rd", lat, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_extra_ready", ready2, 1'b0);
        end

        // Reset while the halfword write sits in MERGE.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b01; addr = 8'h10; wdata = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrg_rst_ready", ready2, 1'b0);
        check("mrg_rst_busy",  busy2,  1'b0);
        check("mrg_rst_rdata", rdata2, 32'd0);
        reset = 1'b0;
        do_op(1'b0, 2'b10, 8'h10, 32'd0, 1'b0, got, gerr, lat);
        check("rd_after_mrg_rst", got, 32'hDEAA_BEEF);

        // Misaligned word read.
        do_op(1'b0, 2'b10, 8'h11, 32'd0, 1'b0, got, gerr, lat);
        check("lat_misalign", lat, 4);
`ifdef MEM_RESPONDER_MISALIGN_EXC_EN
        check("misalign_err",   gerr, 1'b1);
        check("misalign_rdata", got,  32'd0);
`else
        check("misalign_err",   gerr, 1'b0);
        check("misalign_rdata", got,  32'hDEAA_BEEF);
`endif
        do_op(1'b0, 2'b10, 8'h10, 32'd0, 1'b0, got, gerr, lat);
        check("rd_after_misalign", got, 32'hDEAA_BEEF);

        // Upper halfword lanes and the top of the address space.
        do_op(1'b1, 2'b10, 8'h14, 32'h1122_3344, 1'b0, got, gerr, lat);
        do_op(1'b1, 2'b01, 8'h16, 32'h0000_CAFE, 1'b0, got, gerr, lat);
        check("lat_half_wr", lat, 5);
        do_op(1'b0, 2'b10, 8'h14, 32'd0, 1'b0, got, gerr, lat);
        check("rd_word_14", got, 32'hCAFE_3344);
        do_op(1'b1, 2'b10, 8'hFC, 32'hA1B2_C3D4, 1'b0, got, gerr, lat);
        do_op(1'b0, 2'b00, 8'hFF, 32'd0, 1'b0, got, gerr, lat);
        check("rd_byte_ff", got, 32'h0000_00A1);
        do_op(1'b0, 2'b01, 8'hFE, 32'd0, 1'b0, got, gerr, lat);
        check("rd_half_fe", got, 32'h0000_A1B2);
        do_op(1'b0, 2'b10, 8'h00, 32'd0, 1'b0, got, gerr, lat);
        check("rd_word_00", got, 32'h0000_0000);

        // LATENCY=0 instance with req held high across a sequence of accesses.
        begin
            int last_rdy;
            int k;
            int budget;
            @(negedge clk);
            we = h_we[0]; size = h_sz[0]; addr = h_ad[0]; wdata = h_wd[0];
            req0 = 1'b1;
            k = 0; last_rdy = 0; budget = 0;
            while (k < 6 && budget < 60) begin
                @(negedge clk);
                budget++;
                if (ready0) begin
                    if (!h_we[k]) check("hold_rdata", rdata0, h_exp[k]);
                    if (k > 0) check("hold_gap", cyc - last_rdy, 3);
                    last_rdy = cyc;
                    k++;
                    if (k < 6) begin
                        we = h_we[k]; size = h_sz[k]; addr = h_ad[k]; wdata = h_wd[k];
                    end else begin
                        req0 = 1'b0;
                    end
                end
            end
            req0 = 1'b0;
            check("hold_count", k, 6);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
